// File: rtl/cache_mem_arb.sv
// cache_mem_arb: round-robin burst arbiter sharing one Avalon-MM master port
// between the instruction-cache (s0) and data-cache (s1) bus masters.
// A grant is held for a whole burst, including every read-data beat, so at
// most one transaction is outstanding on m0 at any time.
module cache_mem_arb #(
    parameter int BURST_COUNT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rest,

    input  logic [31:0]                  s0_address,
    input  logic [3:0]                   s0_byteEnable,
    input  logic                         s0_read,
    input  logic                         s0_write,
    input  logic [31:0]                  s0_writeData,
    input  logic                         s0_beginBurstTransfer,
    input  logic [BURST_COUNT_WIDTH-1:0] s0_burstCount,
    output logic                         s0_waitRequest,
    output logic [31:0]                  s0_readData,
    output logic                         s0_readDataValid,

    input  logic [31:0]                  s1_address,
    input  logic [3:0]                   s1_byteEnable,
    input  logic                         s1_read,
    input  logic                         s1_write,
    input  logic [31:0]                  s1_writeData,
    input  logic                         s1_beginBurstTransfer,
    input  logic [BURST_COUNT_WIDTH-1:0] s1_burstCount,
    output logic                         s1_waitRequest,
    output logic [31:0]                  s1_readData,
    output logic                         s1_readDataValid,

    output logic [31:0]                  m0_address,
    output logic [3:0]                   m0_byteEnable,
    output logic                         m0_read,
    output logic                         m0_write,
    output logic [31:0]                  m0_writeData,
    output logic                         m0_beginBurstTransfer,
    output logic [BURST_COUNT_WIDTH-1:0] m0_burstCount,
    input  logic                         m0_waitRequest,
    input  logic [31:0]                  m0_readData,
    input  logic                         m0_readDataValid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CMD  = 2'd1,
        RD_DATA = 2'd2,
        WR      = 2'd3
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic                         r_owner;
    logic                         r_last_owner;
    logic                         r_first;
    logic [BURST_COUNT_WIDTH-1:0] r_beats;
    logic [BURST_COUNT_WIDTH-1:0] r_count;

    logic                         w_req0;
    logic                         w_req1;
    logic                         w_req_any;
    logic                         w_grant;
    logic                         w_grant_read;
    logic [BURST_COUNT_WIDTH-1:0] w_grant_bc;
    logic [BURST_COUNT_WIDTH-1:0] w_grant_beats;

    logic [31:0]                  w_o_address;
    logic [3:0]                   w_o_byteEnable;
    logic                         w_o_write;
    logic [31:0]                  w_o_writeData;

    logic                         w_beat;
    logic [BURST_COUNT_WIDTH-1:0] w_count_nxt;
    logic                         w_done;
    logic                         w_owner_wait;
    logic                         w_owner_rdv;

    // The arbiter builds its own burst-start pulse, so the masters' pulses are unused.
    logic w_unused;
    assign w_unused = s0_beginBurstTransfer ^ s1_beginBurstTransfer;

    // Read data is broadcast; only the valid strobe is steered to the owner.
    assign s0_readData = m0_readData;
    assign s1_readData = m0_readData;

    // Request decode and round-robin grant selection.
    always_comb begin
        w_req0    = s0_read | s0_write;
        w_req1    = s1_read | s1_write;
        w_req_any = w_req0 | w_req1;
        if (w_req0 && w_req1) begin
            w_grant = ~r_last_owner;
        end else begin
            w_grant = w_req1;
        end
        w_grant_read  = w_grant ? s1_read : s0_read;
        w_grant_bc    = w_grant ? s1_burstCount : s0_burstCount;
        w_grant_beats = (w_grant_bc == '0) ? BURST_COUNT_WIDTH'(1) : w_grant_bc;
    end

    // Owner command mux and beat counting.
    always_comb begin
        w_o_address    = r_owner ? s1_address    : s0_address;
        w_o_byteEnable = r_owner ? s1_byteEnable : s0_byteEnable;
        w_o_write      = r_owner ? s1_write      : s0_write;
        w_o_writeData  = r_owner ? s1_writeData  : s0_writeData;

        w_beat = 1'b0;
        if ((r_state == RD_CMD) || (r_state == RD_DATA)) begin
            w_beat = m0_readDataValid;
        end else if (r_state == WR) begin
            w_beat = w_o_write & ~m0_waitRequest;
        end
        w_count_nxt = w_beat ? (r_count + BURST_COUNT_WIDTH'(1)) : r_count;
        w_done      = (w_count_nxt == r_beats);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rest) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant bookkeeping: owner, fairness pointer, burst length and beat counter.
    always_ff @(posedge clk) begin
        if (rest) begin
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_first      <= 1'b0;
            r_beats      <= '0;
            r_count      <= '0;
        end else begin
            r_first <= (r_state == IDLE) && w_req_any;
            if ((r_state == IDLE) && w_req_any) begin
                r_owner      <= w_grant;
                r_last_owner <= w_grant;
                r_beats      <= w_grant_beats;
                r_count      <= '0;
            end else begin
                r_count <= w_count_nxt;
            end
        end
    end

    // Next-state and output decode; outside a burst nothing is driven on m0.
    always_comb begin
        w_state_nxt           = r_state;
        m0_address            = '0;
        m0_byteEnable         = '0;
        m0_read               = 1'b0;
        m0_write              = 1'b0;
        m0_writeData          = '0;
        m0_beginBurstTransfer = 1'b0;
        m0_burstCount         = '0;
        w_owner_wait          = 1'b1;
        w_owner_rdv           = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_req_any) begin
                    w_state_nxt = w_grant_read ? RD_CMD : WR;
                end
            end
            RD_CMD: begin
                m0_read               = 1'b1;
                m0_address            = w_o_address;
                m0_byteEnable         = w_o_byteEnable;
                m0_burstCount         = r_beats;
                m0_beginBurstTransfer = r_first;
                w_owner_wait          = m0_waitRequest;
                w_owner_rdv           = m0_readDataValid;
                if (!m0_waitRequest) begin
                    w_state_nxt = w_done ? IDLE : RD_DATA;
                end
            end
            RD_DATA: begin
                w_owner_rdv = m0_readDataValid;
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
            end
            WR: begin
                m0_write              = w_o_write;
                m0_address            = w_o_address;
                m0_byteEnable         = w_o_byteEnable;
                m0_writeData          = w_o_writeData;
                m0_burstCount         = r_beats;
                m0_beginBurstTransfer = r_first;
                w_owner_wait          = m0_waitRequest;
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        s0_waitRequest   = 1'b1;
        s1_waitRequest   = 1'b1;
        s0_readDataValid = 1'b0;
        s1_readDataValid = 1'b0;
        if (r_state != IDLE) begin
            if (r_owner) begin
                s1_waitRequest   = w_owner_wait;
                s1_readDataValid = w_owner_rdv;
            end else begin
                s0_waitRequest   = w_owner_wait;
                s0_readDataValid = w_owner_rdv;
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_arb.sv
// tb_cache_mem_arb: directed, cycle-by-cycle checks of cache_mem_arb.
module tb_cache_mem_arb;

    localparam int BCW = 8;

    logic            clk;
    logic            rest;
    logic [31:0]     s0_address, s1_address;
    logic [3:0]      s0_byteEnable, s1_byteEnable;
    logic            s0_read, s0_write, s1_read, s1_write;
    logic [31:0]     s0_writeData, s1_writeData;
    logic            s0_beginBurstTransfer, s1_beginBurstTransfer;
    logic [BCW-1:0]  s0_burstCount, s1_burstCount;
    logic            s0_waitRequest, s1_waitRequest;
    logic [31:0]     s0_readData, s1_readData;
    logic            s0_readDataValid, s1_readDataValid;
    logic [31:0]     m0_address;
    logic [3:0]      m0_byteEnable;
    logic            m0_read, m0_write;
    logic [31:0]     m0_writeData;
    logic            m0_beginBurstTransfer;
    logic [BCW-1:0]  m0_burstCount;
    logic            m0_waitRequest;
    logic [31:0]     m0_readData;
    logic            m0_readDataValid;

    int unsigned n_checks;
    int unsigned n_fail;

    cache_mem_arb #(.BURST_COUNT_WIDTH(BCW)) dut (
        .clk                   (clk),
        .rest                  (rest),
        .s0_address            (s0_address),
        .s0_byteEnable         (s0_byteEnable),
        .s0_read               (s0_read),
        .s0_write              (s0_write),
        .s0_writeData          (s0_writeData),
        .s0_beginBurstTransfer (s0_beginBurstTransfer),
        .s0_burstCount         (s0_burstCount),
        .s0_waitRequest        (s0_waitRequest),
        .s0_readData           (s0_readData),
        .s0_readDataValid      (s0_readDataValid),
        .s1_address            (s1_address),
        .s1_byteEnable         (s1_byteEnable),
        .s1_read               (s1_read),
        .s1_write              (s1_write),
        .s1_writeData          (s1_writeData),
        .s1_beginBurstTransfer (s1_beginBurstTransfer),
        .s1_burstCount         (s1_burstCount),
        .s1_waitRequest        (s1_waitRequest),
        .s1_readData           (s1_readData),
        .s1_readDataValid      (s1_readDataValid),
        .m0_address            (m0_address),
        .m0_byteEnable         (m0_byteEnable),
        .m0_read               (m0_read),
        .m0_write              (m0_write),
        .m0_writeData          (m0_writeData),
        .m0_beginBurstTransfer (m0_beginBurstTransfer),
        .m0_burstCount         (m0_burstCount),
        .m0_waitRequest        (m0_waitRequest),
        .m0_readData           (m0_readData),
        .m0_readDataValid      (m0_readDataValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling, well before the next edge.
    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        s0_address = '0; s0_byteEnable = '0; s0_read = 0; s0_write = 0;
        s0_writeData = '0; s0_beginBurstTransfer = 0; s0_burstCount = '0;
        s1_address = '0; s1_byteEnable = '0; s1_read = 0; s1_write = 0;
        s1_writeData = '0; s1_beginBurstTransfer = 0; s1_burstCount = '0;
        m0_waitRequest = 0; m0_readData = '0; m0_readDataValid = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rest = 1;
        cyc();
        rest = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_m0_read"},   m0_read, 0);
        check_eq({tag, "_m0_write"},  m0_write, 0);
        check_eq({tag, "_begin"},     m0_beginBurstTransfer, 0);
        check_eq({tag, "_m0_addr"},   m0_address, 0);
        check_eq({tag, "_m0_be"},     m0_byteEnable, 0);
        check_eq({tag, "_m0_wdata"},  m0_writeData, 0);
        check_eq({tag, "_m0_bc"},     m0_burstCount, 0);
        check_eq({tag, "_s0_wait"},   s0_waitRequest, 1);
        check_eq({tag, "_s1_wait"},   s1_waitRequest, 1);
        check_eq({tag, "_s0_rdv"},    s0_readDataValid, 0);
        check_eq({tag, "_s1_rdv"},    s1_readDataValid, 0);
    endtask

    logic [31:0] wr_beat [4];
    logic        wt_tab  [8];
    int unsigned idx_tab [8];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rest     = 0;
        clear_inputs();
        cyc();

        // ---- reset values, with stray inputs that must not leak out ----
        do_reset();
        m0_readDataValid = 1;
        s0_writeData     = 32'hFFFF_FFFF;
        s1_address       = 32'h1234_5678;
        settle();
        check_idle_outputs("rst");
        m0_readDataValid = 0;
        s0_writeData     = '0;
        s1_address       = '0;

        // ---- single read on s0, burstCount 1 ----
        cyc();  // N
        s0_read = 1; s0_address = 32'h0000_1000; s0_byteEnable = 4'hF; s0_burstCount = 1;
        settle();
        check_eq("t1_N_s0_wait", s0_waitRequest, 1);
        check_eq("t1_N_m0_read", m0_read, 0);
        cyc();  // N+1
        settle();
        check_eq("t1_cmd_read",  m0_read, 1);
        check_eq("t1_cmd_begin", m0_beginBurstTransfer, 1);
        check_eq("t1_cmd_addr",  m0_address, 32'h0000_1000);
        check_eq("t1_cmd_bc",    m0_burstCount, 1);
        check_eq("t1_cmd_be",    m0_byteEnable, 4'hF);
        check_eq("t1_cmd_s0w",   s0_waitRequest, 0);
        check_eq("t1_cmd_s1w",   s1_waitRequest, 1);
        cyc();  // N+2
        s0_read = 0;
        settle();
        check_eq("t1_dat_read",  m0_read, 0);
        check_eq("t1_dat_begin", m0_beginBurstTransfer, 0);
        check_eq("t1_dat_s0w",   s0_waitRequest, 1);
        cyc();  // N+3
        m0_readDataValid = 1; m0_readData = 32'hDEAD_BEEF;
        settle();
        check_eq("t1_rdv",   s0_readDataValid, 1);
        check_eq("t1_rdata", s0_readData, 32'hDEAD_BEEF);
        check_eq("t1_s1rdv", s1_readDataValid, 0);
        cyc();  // N+4: idle, a stray valid is dropped
        settle();
        check_eq("t1_idle_rdv",  s0_readDataValid, 0);
        check_eq("t1_idle_read", m0_read, 0);
        check_eq("t1_idle_s0w",  s0_waitRequest, 1);
        m0_readDataValid = 0;

        // ---- simultaneous reads after reset: s0 first, then s1, then s0 again ----
        do_reset();     // N
        s0_read = 1; s0_address = 32'h0000_2000; s0_byteEnable = 4'hF; s0_burstCount = 1;
        s1_read = 1; s1_address = 32'h0000_3000; s1_byteEnable = 4'hF; s1_burstCount = 1;
        settle();
        check_eq("t2_N_s1w", s1_waitRequest, 1);
        cyc();  // N+1
        settle();
        check_eq("t2_g0_addr", m0_address, 32'h0000_2000);
        check_eq("t2_g0_s0w",  s0_waitRequest, 0);
        check_eq("t2_g0_s1w",  s1_waitRequest, 1);
        cyc();  // N+2
        s0_read = 0; m0_readDataValid = 1; m0_readData = 32'h1111_1111;
        settle();
        check_eq("t2_b0_s0rdv", s0_readDataValid, 1);
        check_eq("t2_b0_s1rdv", s1_readDataValid, 0);
        check_eq("t2_b0_s1w",   s1_waitRequest, 1);
        cyc();  // N+3
        m0_readDataValid = 0;
        settle();
        check_eq("t2_turn_s1w",  s1_waitRequest, 1);
        check_eq("t2_turn_read", m0_read, 0);
        cyc();  // N+4
        settle();
        check_eq("t2_g1_read",  m0_read, 1);
        check_eq("t2_g1_addr",  m0_address, 32'h0000_3000);
        check_eq("t2_g1_begin", m0_beginBurstTransfer, 1);
        check_eq("t2_g1_s1w",   s1_waitRequest, 0);
        check_eq("t2_g1_s0w",   s0_waitRequest, 1);
        cyc();  // N+5
        s1_read = 0; m0_readDataValid = 1; m0_readData = 32'h2222_2222;
        settle();
        check_eq("t2_b1_s1rdv", s1_readDataValid, 1);
        check_eq("t2_b1_data",  s1_readData, 32'h2222_2222);
        check_eq("t2_b1_s0rdv", s0_readDataValid, 0);
        cyc();  // N+6
        m0_readDataValid = 0; s0_read = 1; s1_read = 1;
        settle();
        check_eq("t2_idle2_read", m0_read, 0);
        cyc();  // N+7
        settle();
        check_eq("t2_tie2_addr", m0_address, 32'h0000_2000);
        check_eq("t2_tie2_s0w",  s0_waitRequest, 0);
        check_eq("t2_tie2_s1w",  s1_waitRequest, 1);
        s1_read = 0;
        cyc();  // N+8
        s0_read = 0; m0_readDataValid = 1; m0_readData = 32'h3333_3333;
        settle();
        check_eq("t2_b2_s0rdv", s0_readDataValid, 1);
        cyc();  // N+9
        m0_readDataValid = 0;
        settle();
        check_eq("t2_end_s0w",  s0_waitRequest, 1);
        check_eq("t2_end_read", m0_read, 0);

        // ---- s0 read burst of 4, s1 write arrives during beat 2 ----
        cyc();  // N
        s0_read = 1; s0_address = 32'h0000_4000; s0_burstCount = 4;
        settle();
        cyc();  // N+1
        settle();
        check_eq("t3_cmd_bc",   m0_burstCount, 4);
        check_eq("t3_cmd_read", m0_read, 1);
        cyc();  // N+2 beat 1
        s0_read = 0; m0_readDataValid = 1; m0_readData = 32'hA000_0001;
        settle();
        check_eq("t3_b1_rdv",  s0_readDataValid, 1);
        check_eq("t3_b1_data", s0_readData, 32'hA000_0001);
        cyc();  // N+3 beat 2, s1 write arrives
        m0_readData = 32'hA000_0002;
        s1_write = 1; s1_address = 32'h0000_5000; s1_writeData = 32'h5555_AAAA;
        s1_burstCount = 1; s1_byteEnable = 4'h3;
        settle();
        check_eq("t3_b2_s1w",   s1_waitRequest, 1);
        check_eq("t3_b2_s1rdv", s1_readDataValid, 0);
        check_eq("t3_b2_data",  s0_readData, 32'hA000_0002);
        cyc();  // N+4 gap
        m0_readDataValid = 0;
        settle();
        check_eq("t3_gap_rdv",   s0_readDataValid, 0);
        check_eq("t3_gap_write", m0_write, 0);
        cyc();  // N+5 beat 3
        m0_readDataValid = 1; m0_readData = 32'hA000_0003;
        settle();
        check_eq("t3_b3_rdv", s0_readDataValid, 1);
        cyc();  // N+6 beat 4
        m0_readData = 32'hA000_0004;
        settle();
        check_eq("t3_b4_rdv",   s0_readDataValid, 1);
        check_eq("t3_b4_s1rdv", s1_readDataValid, 0);
        check_eq("t3_b4_s1w",   s1_waitRequest, 1);
        cyc();  // N+7 idle
        m0_readDataValid = 0;
        settle();
        check_eq("t3_idle_s1w",   s1_waitRequest, 1);
        check_eq("t3_idle_write", m0_write, 0);
        cyc();  // N+8 s1 write granted
        settle();
        check_eq("t3_wr_write", m0_write, 1);
        check_eq("t3_wr_addr",  m0_address, 32'h0000_5000);
        check_eq("t3_wr_data",  m0_writeData, 32'h5555_AAAA);
        check_eq("t3_wr_be",    m0_byteEnable, 4'h3);
        check_eq("t3_wr_begin", m0_beginBurstTransfer, 1);
        check_eq("t3_wr_bc",    m0_burstCount, 1);
        check_eq("t3_wr_s1w",   s1_waitRequest, 0);
        cyc();  // N+9
        s1_write = 0;
        settle();
        check_eq("t3_end_write", m0_write, 0);
        check_eq("t3_end_s1w",   s1_waitRequest, 1);

        // ---- s1 write burst of 4 with downstream stalls on beats 2 and 3 ----
        for (int i = 0; i < 4; i++) wr_beat[i] = 32'hC0DE_0000 + 32'(i);
        wt_tab  = '{0, 1, 1, 0, 1, 1, 0, 0};
        idx_tab = '{0, 1, 1, 1, 2, 2, 2, 3};
        cyc();  // N
        s1_write = 1; s1_address = 32'h0000_6000; s1_burstCount = 4;
        s1_byteEnable = 4'hF; s1_writeData = wr_beat[0];
        settle();
        for (int c = 0; c < 8; c++) begin
            cyc();
            m0_waitRequest = wt_tab[c];
            s1_writeData   = wr_beat[idx_tab[c]];
            settle();
            check_eq($sformatf("t4_c%0d_write", c), m0_write, 1);
            check_eq($sformatf("t4_c%0d_data", c),  m0_writeData, wr_beat[idx_tab[c]]);
            check_eq($sformatf("t4_c%0d_s1w", c),   s1_waitRequest, wt_tab[c]);
            check_eq($sformatf("t4_c%0d_begin", c), m0_beginBurstTransfer, (c == 0));
            if (c == 0) check_eq("t4_bc", m0_burstCount, 4);
        end
        cyc();  // after 4th acceptance
        s1_write = 0; m0_waitRequest = 0;
        settle();
        check_eq("t4_end_write", m0_write, 0);
        check_eq("t4_end_s1w",   s1_waitRequest, 1);

        // ---- burstCount 0 write is one beat ----
        cyc();  // N
        s0_write = 1; s0_burstCount = 0; s0_address = 32'h0000_7000;
        s0_writeData = 32'h0000_0077; s0_byteEnable = 4'hF;
        settle();
        cyc();  // N+1
        settle();
        check_eq("t5_bc",    m0_burstCount, 1);
        check_eq("t5_write", m0_write, 1);
        check_eq("t5_data",  m0_writeData, 32'h0000_0077);
        cyc();  // N+2
        s0_write = 0;
        settle();
        check_eq("t5_end_s0w", s0_waitRequest, 1);

        // ---- reset during an 8-beat read after 2 beats ----
        cyc();  // N
        s0_read = 1; s0_address = 32'h0000_8000; s0_burstCount = 8;
        settle();
        cyc();  // N+1
        settle();
        check_eq("t6_bc", m0_burstCount, 8);
        cyc();  // N+2 beat 1
        s0_read = 0; m0_readDataValid = 1; m0_readData = 32'hB000_0001;
        settle();
        cyc();  // N+3 beat 2
        m0_readData = 32'hB000_0002;
        settle();
        check_eq("t6_b2_rdv", s0_readDataValid, 1);
        cyc();  // N+4 reset asserted
        m0_readDataValid = 0; rest = 1;
        settle();
        cyc();  // N+5 post-reset, late beat arrives, tie requested
        rest = 0; m0_readDataValid = 1; m0_readData = 32'hB000_0003;
        s0_read = 1; s0_address = 32'h0000_8100; s0_burstCount = 1;
        s1_read = 1; s1_address = 32'h0000_9100; s1_burstCount = 1;
        settle();
        check_idle_outputs("t6_rst");
        cyc();  // N+6
        m0_readDataValid = 0;
        settle();
        check_eq("t6_tie_addr", m0_address, 32'h0000_8100);
        check_eq("t6_tie_s0w",  s0_waitRequest, 0);
        check_eq("t6_tie_s1w",  s1_waitRequest, 1);
        s1_read = 0;
        cyc();  // N+7
        s0_read = 0; m0_readDataValid = 1; m0_readData = 32'hB000_0010;
        settle();
        check_eq("t6_fin_rdv", s0_readDataValid, 1);
        cyc();  // N+8
        m0_readDataValid = 0;
        settle();
        check_eq("t6_end_read", m0_read, 0);
        check_eq("t6_end_s0w",  s0_waitRequest, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
